// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment by bitslip search plus data and
// control-token decode of one deserialized 10-bit channel stream.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 8
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic       locked,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [1:0] ctrl_out,
  output logic       ctrl_valid
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t            state_reg;
  logic [RUN_W-1:0]  run_reg;
  logic [RUN_W-1:0]  run_next;
  logic [TMO_W-1:0]  tmo_reg;
  logic [WAIT_W-1:0] wait_reg;

  logic       is_ctrl;
  logic [1:0] ctrl_code;
  logic [7:0] d_word;
  logic [7:0] dec_word;
  logic       run_hit;
  logic       lock_next;

  // Recognise the four blanking control tokens; everything else is data.
  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_code = 2'b00;
    case (sym_in)
      10'h354: ctrl_code = 2'b00;
      10'h0AB: ctrl_code = 2'b01;
      10'h154: ctrl_code = 2'b10;
      10'h2AB: ctrl_code = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase
  end

  // Undo the optional inversion, then undo the XOR/XNOR transition chain.
  assign d_word      = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
  assign dec_word[0] = d_word[0];

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_word[gi] = sym_in[8] ? (d_word[gi] ^ d_word[gi-1])
                                      : ~(d_word[gi] ^ d_word[gi-1]);
    end
  endgenerate

  // Consecutive-token run: saturates, clears on data, held at zero while settling.
  always_comb begin
    run_next = run_reg;
    run_hit  = 1'b0;
    if (state_reg == ST_SLIP_WAIT) begin
      run_next = '0;
    end else if (is_ctrl) begin
      if (run_reg != RUN_MAX) begin
        run_next = run_reg + RUN_W'(1);
        run_hit  = (run_reg == RUN_LAST);
      end
    end else begin
      run_next = '0;
    end
  end

  // Lock state one edge ahead, so valids can never be seen while unlocked.
  always_comb begin
    lock_next = 1'b0;
    case (state_reg)
      ST_SEARCH: lock_next = run_hit;
      ST_LOCKED: lock_next = run_hit || (tmo_reg != TMO_LAST);
      default:   lock_next = 1'b0;
    endcase
  end

  // Run counter register.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      run_reg <= '0;
    end else begin
      run_reg <= run_next;
    end
  end

  // Alignment FSM: search for a token run, slip on timeout, settle, and track lock.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_reg <= ST_SEARCH;
      tmo_reg   <= '0;
      wait_reg  <= '0;
      bitslip   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state_reg)
        ST_SEARCH: begin
          if (run_hit) begin
            state_reg <= ST_LOCKED;
            locked    <= 1'b1;
            tmo_reg   <= '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_reg <= ST_SLIP_WAIT;
            bitslip   <= 1'b1;
            tmo_reg   <= '0;
            wait_reg  <= '0;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        ST_SLIP_WAIT: begin
          tmo_reg <= '0;
          if (wait_reg == WAIT_LAST) begin
            state_reg <= ST_SEARCH;
            wait_reg  <= '0;
          end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (run_hit) begin
            tmo_reg <= '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_reg <= ST_SEARCH;
            locked    <= 1'b0;
            tmo_reg   <= '0;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        default: begin
          state_reg <= ST_SEARCH;
          locked    <= 1'b0;
          tmo_reg   <= '0;
          wait_reg  <= '0;
        end
      endcase
    end
  end

  // Decoded outputs: registered one cycle after sampling, held when not valid.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      ctrl_out   <= 2'b00;
      ctrl_valid <= 1'b0;
    end else begin
      data_valid <= lock_next && !is_ctrl;
      ctrl_valid <= lock_next && is_ctrl;
      if (lock_next && !is_ctrl) begin
        data_out <= dec_word;
      end
      if (lock_next && is_ctrl) begin
        ctrl_out <= ctrl_code;
      end
    end
  end

endmodule
